// File: rtl/snake_grid_renderer_if.sv
// snake_grid_renderer_if: pixel scan, symbol ROM and segment-load signals of the snake grid renderer
interface snake_grid_renderer_if #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int COORD_BIT         = 7,
    parameter int FRUIT_COUNT       = 1,
    parameter int BLOCK_SIZE        = 5,
    parameter int COLOR_BIT         = 2
);
    localparam int SYM_W   = BLOCK_SIZE*BLOCK_SIZE*COLOR_BIT;
    localparam int PIX_BIT = $clog2(BLOCK_SIZE*BLOCK_SIZE);
    logic [PIXEL_DISPLAY_BIT:0]       X, Y;
    logic                             frame_start;
    logic                             load_valid, load_ready, load_last;
    logic [COORD_BIT-1:0]             load_x, load_y;
    logic [FRUIT_COUNT*COORD_BIT-1:0] fruit_x, fruit_y;
    logic [1:0]                       selected_figure;
    logic [PIX_BIT-1:0]               pixel_index;
    logic [SYM_W-1:0]                 selected_symbol;
    logic                             game_area, game_enable;
    logic [COLOR_BIT-1:0]             game_data;
    logic                             self_hit, load_overflow;
    modport master (
        output X, Y, frame_start, load_valid, load_last, load_x, load_y, fruit_x, fruit_y, selected_symbol,
        input  load_ready, selected_figure, pixel_index, game_area, game_enable, game_data, self_hit, load_overflow
    );
    modport slave (
        input  X, Y, frame_start, load_valid, load_last, load_x, load_y, fruit_x, fruit_y, selected_symbol,
        output load_ready, selected_figure, pixel_index, game_area, game_enable, game_data, self_hit, load_overflow
    );
endinterface

// File: rtl/snake_grid_renderer.sv
// snake_grid_renderer: grid classification, symbol pixel fetch and double-buffered snake segment store
module snake_grid_renderer #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int COORD_BIT         = 7,
    parameter int SNAKE_LENGTH_BIT  = 4,
    parameter int SNAKE_LENGTH_MAX  = 16,
    parameter int FRUIT_COUNT       = 1,
    parameter int BLOCK_SIZE        = 5,
    parameter int GRID_W            = 124,
    parameter int GRID_H            = 81,
    parameter int X_off             = 58,
    parameter int Y_off             = 43,
    parameter int COLOR_BIT         = 2
) (
    input logic                clock_25,
    input logic                reset,
    snake_grid_renderer_if.slave bus
);
    localparam int PD      = PIXEL_DISPLAY_BIT + 1;
    localparam int SYM_W   = BLOCK_SIZE*BLOCK_SIZE*COLOR_BIT;
    localparam int PIX_BIT = $clog2(BLOCK_SIZE*BLOCK_SIZE);
    localparam int LB      = $clog2(BLOCK_SIZE);
    localparam int CNT_BIT = SNAKE_LENGTH_BIT + 1;
    localparam int X_END   = X_off + GRID_W*BLOCK_SIZE;
    localparam int Y_END   = Y_off + GRID_H*BLOCK_SIZE;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_t;
    logic [LB-1:0]                    r_xl, r_yl, w_xl, w_yl;
    logic [COORD_BIT-1:0]             r_xb, r_yb, w_xb, w_yb;
    logic                             w_x0, w_xw, w_yw, w_area;
    logic                             w_head, w_body, w_tail, w_fruit, w_hit;
    logic [1:0]                       w_fig, r_fig;
    logic [PIX_BIT-1:0]               w_pix, r_pix;
    logic                             r_hit, r_en;
    logic [COLOR_BIT-1:0]             r_data;
    logic [COORD_BIT-1:0]             r_sx [2][SNAKE_LENGTH_MAX];
    logic [COORD_BIT-1:0]             r_sy [2][SNAKE_LENGTH_MAX];
    logic [FRUIT_COUNT*COORD_BIT-1:0] r_fx, r_fy;
    logic                             r_sel, r_complete, r_live, r_ovf, r_self;
    logic [CNT_BIT-1:0]               r_cnt, r_len;
    logic [SNAKE_LENGTH_BIT-1:0]      r_idx;
    scan_t                            r_state;
    logic                             w_full, w_ready, w_acc;
    // Current pixel's local/block position: x restarts at the first game column, y at the first game row
    assign w_x0   = bus.X == PD'(X_off);
    assign w_xw   = r_xl == LB'(BLOCK_SIZE-1);
    assign w_xl   = (w_x0 || w_xw) ? '0 : r_xl + 1'b1;
    assign w_xb   = w_x0 ? '0 : (w_xw ? r_xb + 1'b1 : r_xb);
    assign w_yl   = (bus.Y == PD'(Y_off)) ? '0 : r_yl;
    assign w_yb   = (bus.Y == PD'(Y_off)) ? '0 : r_yb;
    assign w_yw   = w_yl == LB'(BLOCK_SIZE-1);
    assign w_area = bus.X >= PD'(X_off) && bus.X < PD'(X_END) && bus.Y >= PD'(Y_off) && bus.Y < PD'(Y_END);
    // Position counters; y steps once per row when the scan leaves the game area
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_xl <= '0;
            r_xb <= '0;
            r_yl <= '0;
            r_yb <= '0;
        end else begin
            r_xl <= w_xl;
            r_xb <= w_xb;
            r_yl <= (bus.X == PD'(X_END)) ? (w_yw ? '0 : w_yl + 1'b1) : w_yl;
            r_yb <= (bus.X == PD'(X_END) && w_yw) ? w_yb + 1'b1 : w_yb;
        end
    end
    // Parallel match of the current block against every active segment and fruit
    always_comb begin
        w_head  = 1'b0;
        w_body  = 1'b0;
        w_tail  = 1'b0;
        w_fruit = 1'b0;
        for (int i = 0; i < SNAKE_LENGTH_MAX; i++)
            if (i < int'(r_len) && r_sx[r_sel][i] == w_xb && r_sy[r_sel][i] == w_yb) begin
                if (i == 0) w_head = 1'b1;
                else if (i == int'(r_len) - 1) w_tail = 1'b1;
                else w_body = 1'b1;
            end
        for (int f = 0; f < FRUIT_COUNT; f++)
            if (r_live && r_fx[f*COORD_BIT +: COORD_BIT] == w_xb && r_fy[f*COORD_BIT +: COORD_BIT] == w_yb)
                w_fruit = 1'b1;
    end
    assign w_hit = w_area && (w_head || w_body || w_tail || w_fruit);
    assign w_fig = w_head ? 2'b00 : w_tail ? 2'b10 : w_body ? 2'b01 : 2'b11;
    assign w_pix = PIX_BIT'(w_yl) * PIX_BIT'(BLOCK_SIZE) + PIX_BIT'(w_xl);
    // Two-stage pixel pipeline: classify, then pick the colour bits out of the ROM word
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_fig  <= '0;
            r_pix  <= '0;
            r_hit  <= 1'b0;
            r_en   <= 1'b0;
            r_data <= '0;
        end else begin
            r_fig  <= w_fig;
            r_pix  <= w_pix;
            r_hit  <= w_hit;
            r_en   <= r_hit;
            r_data <= r_hit ? bus.selected_symbol[SYM_W-1-int'(r_pix)*COLOR_BIT -: COLOR_BIT] : '0;
        end
    end
    assign w_full  = r_cnt == CNT_BIT'(SNAKE_LENGTH_MAX);
    assign w_ready = !r_complete && !w_full && !bus.frame_start;
    assign w_acc   = bus.load_valid && w_ready;
    // Shadow bank write; segment data needs no reset since the active length gates it
    always_ff @(posedge clock_25) begin
        if (w_acc) begin
            r_sx[~r_sel][r_cnt[SNAKE_LENGTH_BIT-1:0]] <= bus.load_x;
            r_sy[~r_sel][r_cnt[SNAKE_LENGTH_BIT-1:0]] <= bus.load_y;
        end
    end
    // Load bookkeeping, frame-start bank swap and the head-versus-body self-collision scan
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_sel      <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_complete <= 1'b0;
            r_live     <= 1'b0;
            r_fx       <= '0;
            r_fy       <= '0;
            r_ovf      <= 1'b0;
            r_self     <= 1'b0;
            r_idx      <= '0;
            r_state    <= IDLE;
        end else begin
            if (bus.load_valid && w_full) r_ovf <= 1'b1;
            if (bus.frame_start && r_complete) begin
                r_sel      <= ~r_sel;
                r_len      <= r_cnt;
                r_fx       <= bus.fruit_x;
                r_fy       <= bus.fruit_y;
                r_live     <= 1'b1;
                r_cnt      <= '0;
                r_complete <= 1'b0;
                r_self     <= 1'b0;
                r_idx      <= SNAKE_LENGTH_BIT'(1);
                r_state    <= (r_cnt >= CNT_BIT'(2)) ? SCAN : DONE;
            end else begin
                if (w_acc) begin
                    r_cnt      <= r_cnt + 1'b1;
                    r_complete <= bus.load_last;
                end
                if (r_state == SCAN && r_sx[r_sel][r_idx] == r_sx[r_sel][0] && r_sy[r_sel][r_idx] == r_sy[r_sel][0])
                    r_self <= 1'b1;
                if (r_state == SCAN) r_idx <= r_idx + 1'b1;
                r_state <= (r_state == SCAN) ? (({1'b0, r_idx} == r_len - 1'b1) ? DONE : SCAN)
                                             : IDLE;
            end
        end
    end
    assign bus.load_ready      = w_ready;
    assign bus.game_area       = w_area;
    assign bus.selected_figure = r_fig;
    assign bus.pixel_index     = r_pix;
    assign bus.game_enable     = r_en;
    assign bus.game_data       = r_data;
    assign bus.self_hit        = r_self;
    assign bus.load_overflow   = r_ovf;
endmodule

// File: tb/tb_snake_grid_renderer.sv
// tb_snake_grid_renderer: scoreboard bench for the snake grid renderer
module tb_snake_grid_renderer;
    localparam int XO = 58, YO = 43, BS = 5;
    localparam int XE = XO + 124*BS, YE = YO + 81*BS;
    typedef struct packed {logic chk; logic hit; logic [1:0] fig; logic [4:0] pix;} exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    always #20 clk = ~clk;
    snake_grid_renderer_if bus ();
    snake_grid_renderer dut (.clock_25(clk), .reset(rst_n), .bus(bus));
    logic [49:0] rom [4];
    assign bus.selected_symbol = rom[bus.selected_figure];
    int n_chk = 0, n_err = 0;
    int a_x[$], a_y[$], s_x[$], s_y[$];
    int a_fx = 0, a_fy = 0;
    bit a_live = 0, s_done = 0, chk_on = 0, seen;
    exp_t q[$];
    exp_t cur, prev = '0;
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic exp_t classify(input int x, input int y);
        exp_t e = '0;
        int bx, by;
        bit h = 0, b = 0, t = 0, f = 0;
        e.chk = chk_on;
        if (x < XO || x >= XE || y < YO || y >= YE) return e;
        bx = (x - XO) / BS;
        by = (y - YO) / BS;
        e.pix = 5'(((y - YO) % BS) * BS + (x - XO) % BS);
        foreach (a_x[i])
            if (a_x[i] == bx && a_y[i] == by) begin
                if (i == 0) h = 1;
                else if (i == a_x.size() - 1) t = 1;
                else b = 1;
            end
        f = a_live && a_fx == bx && a_fy == by;
        e.hit = h | t | b | f;
        e.fig = h ? 2'd0 : t ? 2'd2 : b ? 2'd1 : 2'd3;
        return e;
    endfunction
    function automatic logic [1:0] sym_bits(input logic [1:0] f, input logic [4:0] p);
        logic [49:0] w;
        w = rom[f];
        return w[49 - 2*p -: 2];
    endfunction
    // expectation for the pixel presented in the cycle ending at this edge
    always @(posedge clk) q.push_back(classify(int'(bus.X), int'(bus.Y)));
    // stage-1 outputs one edge later, stage-2 outputs two edges later
    always begin
        @(posedge clk);
        #1;
        if (prev.chk) begin
            chk("enable", 64'(bus.game_enable), 64'(prev.hit));
            chk("data", 64'(bus.game_data), prev.hit ? 64'(sym_bits(prev.fig, prev.pix)) : 64'd0);
        end
        cur = (q.size() > 0) ? q.pop_front() : '0;
        if (cur.chk && cur.hit) begin
            chk("figure", 64'(bus.selected_figure), 64'(cur.fig));
            chk("pixel_index", 64'(bus.pixel_index), 64'(cur.pix));
        end
        prev = cur;
    end
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.load_valid = 0;
            bus.frame_start = 0;
        end
    endtask
    task automatic pix(input int x, input int y);
        @(negedge clk);
        bus.X = 10'(x);
        bus.Y = 10'(y);
        #1 chk("game_area", 64'(bus.game_area), 64'(x >= XO && x < XE && y >= YO && y < YE));
    endtask
    task automatic sweep(input int row, input int x_to);
        chk_on = 1;
        for (int r = YO; r < row; r++) pix(XE, r);
        for (int x = XO - 1; x <= x_to; x++) pix(x, row);
        pix(XE, row);
        chk_on = 0;
        idle(3);
    endtask
    task automatic beat(input int x, input int y, input bit last, input bit exp_rdy);
        @(negedge clk);
        bus.load_valid = 1;
        bus.load_x = 7'(x);
        bus.load_y = 7'(y);
        bus.load_last = last;
        #1 chk("load_ready", 64'(bus.load_ready), 64'(exp_rdy));
        if (exp_rdy) begin
            s_x.push_back(x);
            s_y.push_back(y);
            s_done = last;
        end
    endtask
    task automatic swap(input int fx, input int fy);
        @(negedge clk);
        bus.load_valid = 0;
        bus.frame_start = 1;
        bus.fruit_x = 7'(fx);
        bus.fruit_y = 7'(fy);
        #1 chk("ready_in_frame_start", 64'(bus.load_ready), 64'd0);
        @(negedge clk);
        bus.frame_start = 0;
        if (s_done) begin
            a_x = s_x;
            a_y = s_y;
            a_fx = fx;
            a_fy = fy;
            a_live = 1;
            s_x.delete();
            s_y.delete();
            s_done = 0;
        end
    endtask
    task automatic check_reset_outputs();
        chk("rst_load_ready", 64'(bus.load_ready), 64'd1);
        chk("rst_game_enable", 64'(bus.game_enable), 64'd0);
        chk("rst_game_data", 64'(bus.game_data), 64'd0);
        chk("rst_self_hit", 64'(bus.self_hit), 64'd0);
        chk("rst_overflow", 64'(bus.load_overflow), 64'd0);
        chk("rst_figure", 64'(bus.selected_figure), 64'd0);
        chk("rst_pixel_index", 64'(bus.pixel_index), 64'd0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        rom[0] = 50'h3_1234_5678_9ABC;
        rom[1] = 50'h2_FEDC_BA98_7654;
        rom[2] = 50'h1_5A5A_A5A5_3C3C;
        rom[3] = 50'h0_C3C3_0F0F_F0F0;
        bus.X = 0; bus.Y = 0; bus.frame_start = 0; bus.load_valid = 0; bus.load_last = 0;
        bus.load_x = 0; bus.load_y = 0; bus.fruit_x = 0; bus.fruit_y = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1;
        idle(2);
        sweep(53, 80);
        beat(3, 2, 1, 1);
        idle(1);
        swap(100, 70);
        sweep(53, 80);
        beat(10, 10, 0, 1);
        beat(11, 10, 0, 1);
        beat(12, 10, 1, 1);
        idle(2);
        sweep(93, 125);
        swap(11, 10);
        sweep(93, 125);
        sweep(53, 80);
        beat(10, 10, 0, 1);
        beat(11, 10, 0, 1);
        beat(12, 10, 1, 1);
        idle(1);
        swap(0, 0);
        sweep(43, 65);
        beat(20, 20, 0, 1);
        beat(21, 20, 0, 1);
        beat(21, 21, 0, 1);
        beat(20, 21, 0, 1);
        beat(20, 20, 1, 1);
        idle(1);
        swap(0, 0);
        chk("self_hit_cleared_at_swap", 64'(bus.self_hit), 64'd0);
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            seen = bus.self_hit;
        end
        chk("self_hit_detect", 64'(seen), 64'd1);
        sweep(143, 168);
        beat(30, 30, 0, 1);
        beat(31, 30, 1, 1);
        idle(1);
        chk("self_hit_held", 64'(bus.self_hit), 64'd1);
        swap(0, 0);
        idle(20);
        chk("self_hit_clear", 64'(bus.self_hit), 64'd0);
        for (int i = 0; i < 17; i++) beat(i, 5, 0, i < 16);
        idle(1);
        chk("overflow_set", 64'(bus.load_overflow), 64'd1);
        chk("ready_when_full", 64'(bus.load_ready), 64'd0);
        swap(0, 0);
        chk("ready_after_noswap", 64'(bus.load_ready), 64'd0);
        sweep(68, 145);
        sweep(193, 220);
        @(negedge clk);
        #5 rst_n = 0;
        #1;
        chk("rst_overflow_cleared", 64'(bus.load_overflow), 64'd0);
        chk("rst_ready_async", 64'(bus.load_ready), 64'd1);
        s_x.delete(); s_y.delete(); s_done = 0;
        a_x.delete(); a_y.delete(); a_live = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle(2);
        for (int i = 0; i < 16; i++) beat(i, 20, i == 15, 1);
        idle(1);
        swap(0, 0);
        idle(3);
        #7 rst_n = 0;
        #1 check_reset_outputs();
        s_x.delete(); s_y.delete(); s_done = 0;
        a_x.delete(); a_y.delete(); a_live = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle(2);
        sweep(143, 140);
        sweep(43, 70);
        beat(5, 0, 0, 1);
        beat(6, 0, 1, 1);
        idle(1);
        swap(0, 0);
        sweep(43, 95);
        idle(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/snake_grid_renderer.md
Name: snake_grid_renderer

Overview:
- Parametrised successor of the snake game-area pixel generator.
- Converts VGA scan coordinates (X,Y) into grid block and local pixel coordinates, and classifies each block as head, body, tail or fruit (up to FRUIT_COUNT fruits).
- Fetches the symbol pixel from an external combinational symbol ROM and returns game_enable/game_data with fixed latency.
- Snake segments arrive over a valid/ready load stream into a double-buffered segment store; banks swap only at frame_start (tear-free), and a head-versus-body self-collision scan runs after each swap.

Parameters:
PIXEL_DISPLAY_BIT, 9, X/Y width minus 1
COORD_BIT, 7, block coordinate width
SNAKE_LENGTH_BIT, 4, segment count/index width
SNAKE_LENGTH_MAX, 16, segment store depth per bank
FRUIT_COUNT, 1, number of fruit inputs
BLOCK_SIZE, 5, block edge in pixels
GRID_W, 124, blocks per row
GRID_H, 81, blocks per column
X_off, 58, first game-area pixel column
Y_off, 43, first game-area pixel row
COLOR_BIT, 2, bits per pixel; SYM_W = BLOCK_SIZE*BLOCK_SIZE*COLOR_BIT

Ports:
clock_25  in  1  25 MHz pixel clock
reset  in  1  asynchronous, active-low
X, Y  in  PIXEL_DISPLAY_BIT+1  scan counters, X advances one per cycle
frame_start  in  1  one-cycle pulse in vertical blank
load_valid  in  1  segment beat valid
load_ready  out  1  segment beat accepted when both high
load_last  in  1  final beat of the snake; beat 0 = head, last beat = tail
load_x, load_y  in  COORD_BIT  segment block coordinates
fruit_x, fruit_y  in  FRUIT_COUNT*COORD_BIT  packed fruit coordinates, sampled at swap
selected_figure  out  2  00 head, 01 body, 10 tail, 11 fruit (to symbol ROM)
pixel_index  out  $clog2(BLOCK_SIZE*BLOCK_SIZE)  row-major pixel index within block
selected_symbol  in  SYM_W  ROM word for selected_figure, combinational
game_area  out  1  current X,Y is inside the grid
game_enable  out  1  game_data valid
game_data  out  COLOR_BIT  pixel colour
self_hit  out  1  head coincides with a body or tail segment in the active bank
load_overflow  out  1  sticky: beat offered while shadow bank full

Behaviour:
- Reset values: all outputs 0 except load_ready=1. Segment counts 0, shadow_complete 0, scan FSM IDLE.
- game_area is combinational:
  - X in [X_off, X_off+GRID_W*BLOCK_SIZE-1]
  - Y in [Y_off, Y_off+GRID_H*BLOCK_SIZE-1]
- Block coordinates:
  - x_block=(X-X_off)/BLOCK_SIZE, x_local=(X-X_off)%BLOCK_SIZE; same for Y.
  - Implemented with counters, no divider.
  - x counters restart at X==X_off; y counters advance when X leaves the area on a row, and restart at Y==Y_off.
- Pipeline, with X,Y presented in cycle n:
  - Cycle n+1 (registered): selected_figure, pixel_index = y_local*BLOCK_SIZE+x_local, and an internal hit flag (hit=0 outside game_area).
  - Cycle n+2 (registered): game_enable=hit; game_data = selected_symbol[SYM_W-1-pixel_index*COLOR_BIT -: COLOR_BIT] when hit, else 0.
  - Latency is exactly 2 cycles on every pixel.
- Classification:
  - Parallel compare against all active segments in one cycle.
  - Priority: HEAD (index 0) > TAIL (index len-1, only if len>=2) > BODY (1..len-2) > FRUIT (lowest fruit index wins).
  - Indices >= active length are ignored. With active length 0, only fruits are drawn.
- Load (shadow bank):
  - On an accepted beat: write to entry count, count++.
  - On load_last: set shadow_complete and drop load_ready until the swap.
  - When count==SNAKE_LENGTH_MAX, load_ready=0; a beat with load_valid=1 sets load_overflow.
  - load_ready is forced 0 in the frame_start cycle.
- Swap at frame_start:
  - If shadow_complete: swap banks, active_len<=count, latch fruits, count<=0, shadow_complete<=0, clear self_hit, start the scan, load_ready<=1.
  - Otherwise: active bank and fruits are unchanged, and the partial shadow load continues.
- Scan FSM: IDLE -> SCAN -> DONE -> IDLE.
  - SCAN compares entry i (1..active_len-1), one per cycle, against the head.
  - Any match sets self_hit, which holds until the next swap.
  - active_len<2 goes straight to DONE. Worst case SNAKE_LENGTH_MAX+1 cycles.
- A reset asserted mid-load or mid-scan clears everything immediately; the active bank is considered empty.

Test Plan:
- Defaults, head (3,2), len 1 loaded then frame_start; scan X=73..77, Y=53 -> selected_figure=00, pixel_index 0..4 at n+1; game_enable=1 with game_data = ROM bits at n+2; X=78 -> game_enable=0.
- Load (10,10),(11,10),(12,10) with load_last, no frame_start -> pixels unchanged (old bank). After frame_start -> (10,10) HEAD, (11,10) BODY, (12,10) TAIL.
- Fruit at (11,10) overlapping body -> BODY drawn. Fruit at (0,0) -> X=58,Y=43 drawn as FRUIT; X=57 -> game_area=0, game_enable=0.
- Load 5 segments with the last equal to the head, then frame_start -> self_hit=1 within 6 cycles. Next non-colliding load + swap -> self_hit=0.
- Offer 17 beats without load_last -> load_ready=0 after 16, load_overflow=1; frame_start -> no swap.
- Assert reset mid-scan and mid-frame -> all outputs 0 and load_ready=1 asynchronously; nothing is drawn until the next complete load + swap.
